// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with round-robin or fixed-priority arbitration
// and valid/ready handshakes on every input channel and the shared output.
module rr_mux_arb #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = 0,
   parameter int SW   = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_sel,
   input  logic            out_ready
);

   logic          accept;
   logic          found;
   logic [SW-1:0] ptr;
   logic [SW-1:0] win;
   logic [SW:0]   idx;
   logic [N-1:0]  grant;
   logic [W-1:0]  sel_data;

   assign accept = !out_valid || out_ready;

   // Scan order starts at ptr and wraps modulo N; one extra bit keeps ptr+k from overflowing.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (MODE == 0) begin
            idx = {1'b0, ptr} + (SW+1)'(k);
            if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
         end else begin
            idx = (SW+1)'(k);
         end
         if (!found && in_valid[idx[SW-1:0]]) begin
            found = 1'b1;
            win   = idx[SW-1:0];
         end
      end
   end

   always_comb begin
      grant    = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (found && (win == SW'(i))) begin
            grant[i] = 1'b1;
            sel_data = in_data[i*W +: W];
         end
      end
   end

   assign in_ready = rst ? '0 : (grant & {N{accept}});

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (accept) begin
         if (found) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= win;
            if (MODE == 0) ptr <= (win == SW'(N-1)) ? '0 : win + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: round-robin N=4, fixed-priority N=4 and
// round-robin N=3 instances driven side by side.
module tb_rr_mux_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] d4 = 32'h33221100;
   logic [23:0] d3 = 24'h221100;

   logic [3:0] v0, r0;  logic ov0, ordy0;  logic [7:0] od0;  logic [1:0] os0;
   logic [3:0] v1, r1;  logic ov1, ordy1;  logic [7:0] od1;  logic [1:0] os1;
   logic [2:0] v2, r2;  logic ov2, ordy2;  logic [7:0] od2;  logic [1:0] os2;

   int errors = 0;
   int checks = 0;
   int exp0 [5] = '{0, 1, 2, 3, 0};
   int exp2 [5] = '{0, 1, 2, 0, 1};

   rr_mux_arb #(.N(4), .W(8), .MODE(0)) u_rr4 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_data(d4), .in_ready(r0),
      .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0));

   rr_mux_arb #(.N(4), .W(8), .MODE(1)) u_fp4 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_data(d4), .in_ready(r1),
      .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1));

   rr_mux_arb #(.N(3), .W(8), .MODE(0)) u_rr3 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_data(d3), .in_ready(r2),
      .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      v0 = 4'b1111; v1 = 4'b1010; v2 = 3'b111;
      ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;

      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_out_valid", 32'(ov0), 32'd0);
         check("rst_out_data", 32'(od0), 32'd0);
         check("rst_out_sel", 32'(os0), 32'd0);
         check("rst_in_ready", 32'(r0), 32'd0);
         check("rst_in_ready_fp", 32'(r1), 32'd0);
         check("rst_in_ready_n3", 32'(r2), 32'd0);
      end

      rst = 1'b0;
      #1;
      check("first_grant_ch0", 32'(r0), 32'h1);
      check("fp_ready", 32'(r1), 32'h2);
      check("n3_first_grant", 32'(r2), 32'h1);

      for (int i = 0; i < 5; i++) begin
         tick();
         check("rr_valid", 32'(ov0), 32'd1);
         check("rr_sel", 32'(os0), 32'(exp0[i]));
         check("rr_data", 32'(od0), 32'(exp0[i] * 8'h11));
         check("n3_sel", 32'(os2), 32'(exp2[i]));
         check("n3_data", 32'(od2), 32'(exp2[i] * 8'h11));
         check("fp_sel", 32'(os1), 32'd1);
         check("fp_data", 32'(od1), 32'h11);
         check("fp_ready_held", 32'(r1), 32'h2);
      end

      tick();
      check("pre_bp_data", 32'(od0), 32'h11);

      ordy0 = 1'b0;
      #1;
      check("bp_ready_zero", 32'(r0), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_valid", 32'(ov0), 32'd1);
         check("bp_data_stable", 32'(od0), 32'h11);
         check("bp_ready", 32'(r0), 32'd0);
      end

      ordy0 = 1'b1;
      #1;
      check("bp_release_ready", 32'(r0), 32'h4);
      tick();
      check("bp_refill_sel", 32'(os0), 32'd2);
      check("bp_refill_data", 32'(od0), 32'h22);

      // ptr is now 3: a lone request on channel 1 must wrap around to it
      v0 = 4'b0010;
      #1;
      check("wrap_ready", 32'(r0), 32'h2);
      tick();
      check("wrap_sel", 32'(os0), 32'd1);
      check("wrap_data", 32'(od0), 32'h11);

      v0 = 4'b0000;
      #1;
      check("idle_ready", 32'(r0), 32'd0);
      tick();
      check("idle_valid", 32'(ov0), 32'd0);
      check("idle_data_hold", 32'(od0), 32'h11);
      check("idle_sel_hold", 32'(os0), 32'd1);

      v0 = 4'b1111;
      #1;
      check("ptr2_ready", 32'(r0), 32'h4);

      v0 = 4'b0001;
      #1;
      check("sparse0_ready", 32'(r0), 32'h1);
      tick();
      check("sparse0_sel", 32'(os0), 32'd0);
      check("sparse0_data", 32'(od0), 32'h00);
      check("sparse0_valid", 32'(ov0), 32'd1);

      v0 = 4'b1111;
      #1;
      check("ptr1_ready", 32'(r0), 32'h2);
      tick();
      check("ptr1_sel", 32'(os0), 32'd1);
      check("ptr1_data", 32'(od0), 32'h11);

      ordy0 = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(r0), 32'd0);
      tick();
      check("midrst_valid", 32'(ov0), 32'd0);
      check("midrst_data", 32'(od0), 32'd0);
      check("midrst_sel", 32'(os0), 32'd0);

      rst = 1'b0;
      ordy0 = 1'b1;
      #1;
      check("post_rst_ready", 32'(r0), 32'h1);
      tick();
      check("post_rst_sel", 32'(os0), 32'd0);
      check("post_rst_valid", 32'(ov0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
